// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe column generator and its LFSR.
package flappy_pkg;

  localparam int ROWS = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic {SPACE, PIPE} pipe_state_t;
  typedef logic [ROWS-1:0] column_t;

  typedef struct packed {
    pipe_state_t state;
    logic [7:0]  lfsr;
    logic [2:0]  gap_top;
  } pipe_debug_t;

  // Fibonacci LFSR, taps 8,6,5,4: shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit LFSR; advances on every clock, independent of game flow.
module lfsr8
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/pipe_column_generator.sv
// Generates the incoming LED column: GAP_COLS empty columns, then PIPE_WIDTH pipe columns.
// Define PIPE_FIXED_GAP_EN to force every gap to FIXED_GAP_TOP instead of the LFSR choice.
module pipe_column_generator
  import flappy_pkg::*;
#(
  parameter int GAP_COLS      = 4,
  parameter int PIPE_WIDTH    = 2,
  parameter int GAP_HEIGHT    = 3,
  parameter int FIXED_GAP_TOP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle,
  input  logic        lose,
  output column_t     last_col,
  output logic        new_pipe,
  output pipe_debug_t debug
);

  localparam int GAP_MAX = ROWS - GAP_HEIGHT;

  if (GAP_COLS < 1 || GAP_COLS > 15) begin : g_bad_gap_cols
    $error("GAP_COLS out of range");
  end
  if (PIPE_WIDTH < 1 || PIPE_WIDTH > 7) begin : g_bad_pipe_width
    $error("PIPE_WIDTH out of range");
  end
  if (GAP_HEIGHT < 2 || GAP_HEIGHT > 5) begin : g_bad_gap_height
    $error("GAP_HEIGHT out of range");
  end
  if (FIXED_GAP_TOP < 0 || FIXED_GAP_TOP > GAP_MAX) begin : g_bad_fixed_top
    $error("FIXED_GAP_TOP out of range");
  end

  pipe_state_t state, state_n;
  logic [3:0]  space_cnt, space_cnt_n;
  logic [2:0]  width_cnt, width_cnt_n;
  logic [2:0]  gap_top, gap_top_n, gap_sel;
  column_t     col_n, pipe_col;
  logic        new_pipe_n;
  logic [7:0]  lfsr_q;
  logic        step;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign step  = cycle & ~lose;
  assign debug = '{state: state, lfsr: lfsr_q, gap_top: gap_top};

  always_comb begin
`ifdef PIPE_FIXED_GAP_EN
    gap_sel = 3'(FIXED_GAP_TOP);
`else
    // Fold out-of-range LFSR values back into 0..GAP_MAX.
    if (int'(lfsr_q[2:0]) <= GAP_MAX) gap_sel = lfsr_q[2:0];
    else                              gap_sel = 3'(int'(lfsr_q[2:0]) - (GAP_MAX + 1));
`endif
  end

  always_comb begin
    pipe_col = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (r >= int'(gap_top) && r < int'(gap_top) + GAP_HEIGHT) pipe_col[r] = 1'b0;
    end
  end

  always_comb begin
    state_n     = state;
    space_cnt_n = space_cnt;
    width_cnt_n = width_cnt;
    gap_top_n   = gap_top;
    col_n       = last_col;
    new_pipe_n  = 1'b0;
    if (step) begin
      case (state)
        SPACE: begin
          col_n = '0;
          if (space_cnt == 4'(GAP_COLS - 1)) begin
            space_cnt_n = '0;
            width_cnt_n = '0;
            gap_top_n   = gap_sel;
            state_n     = PIPE;
          end else begin
            space_cnt_n = space_cnt + 4'd1;
          end
        end
        PIPE: begin
          col_n      = pipe_col;
          new_pipe_n = (width_cnt == 3'd0);
          if (width_cnt == 3'(PIPE_WIDTH - 1)) begin
            width_cnt_n = '0;
            state_n     = SPACE;
          end else begin
            width_cnt_n = width_cnt + 3'd1;
          end
        end
        default: state_n = SPACE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SPACE;
      space_cnt <= '0;
      width_cnt <= '0;
      gap_top   <= '0;
      last_col  <= '0;
      new_pipe  <= 1'b0;
    end else begin
      state     <= state_n;
      space_cnt <= space_cnt_n;
      width_cnt <= width_cnt_n;
      gap_top   <= gap_top_n;
      last_col  <= col_n;
      new_pipe  <= new_pipe_n;
    end
  end

endmodule
